ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Sequencing controller between the PS/2 receiver FIFO (`ps2_keyboard`) and the keyboard display/consumer logic. It drains received scan-code bytes with the receiver's active-low `nextdata_n` pop handshake. It also folds the set-2 prefixes (`E0` extended, `F0` break) into single key events, tracks the held key and counts completed keystrokes. Key events go out on a valid/ready port, so a slow consumer backpressures the receiver FIFO instead of losing bytes.

## Interface
- `CNT_W`, default 8: width of the keystroke counter.
- `clk` input 1: system clock; all state on rising edge.
- `clrn` input 1: reset, asynchronous, active-low.
- `ready` input 1: receiver FIFO non-empty.
- `data` input 8: receiver FIFO head byte, valid while `ready`=1.
- `overflow` input 1: receiver FIFO overflow flag, level.
- `nextdata_n` output 1: active-low pop strobe to receiver; low exactly one cycle per byte consumed.
- `evt_valid` output 1: key event available.
- `evt_ready` input 1: consumer accepts event; transfer when `evt_valid`&`evt_ready`.
- `evt_code` output 8: scan code with prefixes stripped.
- `evt_ext` output 1: code was `E0`-prefixed.
- `evt_brk` output 1: release event (was `F0`-prefixed).
- `evt_rpt` output 1: typematic repeat (make of already-held key).
- `key_held` output 1: a key is currently held.
- `held_code` output 8 / `held_ext` output 1: identity of held key.
- `press_cnt` output CNT_W: completed keystrokes, wraps modulo 2^CNT_W.
- `err` output 1: sticky error; receiver overflow or keyboard error byte seen.

## Operation
- FSM states: IDLE, POP, GAP.
  - IDLE -> POP when `ready`=1 and `evt_valid`=0. `data` is latched into `byte_q` on that edge.
  - POP: `nextdata_n`=0. Classify `byte_q` and update state on the closing edge. Unconditionally -> GAP.
  - GAP: `nextdata_n`=1, so the receiver pointer and `ready` settle. -> IDLE.
- Classification of `byte_q` in POP:
  - `F0`: set `brk_pend`.
  - `E0`: set `ext_pend`.
  - `00` or `FF` (keyboard error/overrun): set `err`, clear both pend flags, no event.
  - `AA`, `FA`, `EE` with no pend flag set: status bytes, discarded silently.
  - Any other byte: load event register with `code`=byte, `ext`=`ext_pend` and `brk`=`brk_pend`. Set `evt_valid`, then clear both pend flags.
- Held-key tracking, applied in the same POP edge as the event load:
  - Make whose code/ext differs from the held key: `held_*`<=code/ext, `key_held`<=1, `evt_rpt`=0.
  - Make equal to the held key while `key_held`=1: `evt_rpt`=1; held state unchanged.
  - Break equal to the held key: `key_held`<=0 and `press_cnt`<=`press_cnt`+1 (wrap).
  - Break of any other key: event emitted, no count, held state unchanged.
- `evt_valid` stays high and every `evt_*` output stays stable until the transfer. `evt_valid` clears on the transfer edge.
- Overflow: a rising edge of `overflow` (registered compare) sets `err` and clears the pend flags. Bytes are still drained normally.
- `err` clears only on reset.

## Timing
- Reset (async, `clrn`=0): state IDLE, `nextdata_n`=1, and every other output, pend flag and `byte_q` is 0.
  - Reset mid-POP aborts the pop immediately. The byte remains in the receiver FIFO.
- Byte consumption: `ready` sampled at edge N; `nextdata_n` low for cycle N+1 only; GAP at N+2; earliest next sample at edge N+3. Peak throughput is 1 byte per 3 cycles.
- Event latency: `evt_valid` rises the cycle after POP, i.e. two edges after `ready` is sampled.
- Backpressure: no byte is sampled while `evt_valid`=1.
  - A transfer at edge T permits sampling at edge T+1 at the earliest, not T.
  - Prefix bytes (`E0`/`F0`) never raise `evt_valid`, so they never stall the FSM.
- Pop strobe: `nextdata_n` is never low for two consecutive cycles and is never low while in IDLE or GAP.

## Structure
- Shared package `ps2_pkg`:
  - byte constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_BAT_OK`=8'hAA, `PS2_ACK`=8'hFA, `PS2_ECHO`=8'hEE, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF;
  - the FSM state enum (IDLE/POP/GAP, 2 bits).
- One natural sub-module, `ps2_byte_classify`: combinational byte -> {is_brk, is_ext, is_err, is_status}. It is reused by the display path's ASCII mapper.
- Event register, held-key register, counter and FSM live in `ps2_key_ctrl`.

## Test plan
- Plain stroke: bytes 1C, F0, 1C with `evt_ready`=1.
  - Two events: {1C, brk=0} then {1C, brk=1}.
  - `press_cnt` 0->1; `key_held` 1 then 0.
  - Exactly 3 single-cycle `nextdata_n` pulses.
- Extended key: E0 75, E0 F0 75.
  - Events {75, ext=1, brk=0} and {75, ext=1, brk=1}; no event for prefixes; `press_cnt`+1.
- Typematic/backpressure: 1C, 1C, 1C, F0 1C with `evt_ready`=0 for 20 cycles, then 1.
  - `nextdata_n` stays high while `evt_valid`=1.
  - Events in order with `evt_rpt`=0,1,1, then break; `press_cnt`=1.
- Noise: AA, then FF, then 1C after a stray F0 preceding FF.
  - AA dropped; `err`=1.
  - The FF clears `brk_pend`, so 1C is a make event, not a break.
- Counter wrap with `CNT_W`=8: 256 complete strokes of 1C -> `press_cnt` returns to 0.
- Reset mid-POP: assert `clrn`=0 during POP of byte 1C, then release.
  - All outputs 0 and `nextdata_n`=1.
  - On release the same 1C is popped once and produces one event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code constants, controller FSM states and the key-event payload.
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] PS2_BREAK  = 8'hF0;
    localparam logic [BYTE_W-1:0] PS2_EXT    = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_BAT_OK = 8'hAA;
    localparam logic [BYTE_W-1:0] PS2_ACK    = 8'hFA;
    localparam logic [BYTE_W-1:0] PS2_ECHO   = 8'hEE;
    localparam logic [BYTE_W-1:0] PS2_ERR0   = 8'h00;
    localparam logic [BYTE_W-1:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic              ext;
        logic              brk;
        logic              rpt;
    } key_evt_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Key-event valid/ready port between the PS/2 sequencing controller and its consumer.
interface ps2_key_ctrl_if;
    import ps2_pkg::*;

    logic              evt_valid;
    logic              evt_ready;
    logic [BYTE_W-1:0] evt_code;
    logic              evt_ext;
    logic              evt_brk;
    logic              evt_rpt;

    modport master (output evt_valid, evt_code, evt_ext, evt_brk, evt_rpt, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_ext, evt_brk, evt_rpt, output evt_ready);

endinterface

// File: rtl/ps2_byte_classify.sv
// Combinational set-2 byte classifier; status flag is raw and must be qualified by the caller.
module ps2_byte_classify
    import ps2_pkg::*;
(
    input  logic [BYTE_W-1:0] data_i,
    output logic              is_brk_c_o,
    output logic              is_ext_c_o,
    output logic              is_err_c_o,
    output logic              is_status_c_o
);

    assign is_brk_c_o    = (data_i == PS2_BREAK);
    assign is_ext_c_o    = (data_i == PS2_EXT);
    assign is_err_c_o    = (data_i == PS2_ERR0) || (data_i == PS2_ERR1);
    assign is_status_c_o = (data_i == PS2_BAT_OK) || (data_i == PS2_ACK) || (data_i == PS2_ECHO);

endmodule

// File: rtl/ps2_key_ctrl.sv
// Drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events, tracks the held key
// and counts completed keystrokes; events leave on a valid/ready port.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ready,
    input  logic [BYTE_W-1:0] data,
    input  logic              overflow,
    output logic              nextdata_n,
    ps2_key_ctrl_if.master    evt,
    output logic              key_held,
    output logic [BYTE_W-1:0] held_code,
    output logic              held_ext,
    output logic [CNT_W-1:0]  press_cnt,
    output logic              err
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              brk_pend_q, brk_pend_d;
    logic              ext_pend_q, ext_pend_d;
    logic              ovf_q;
    logic              evt_valid_q, evt_valid_d;
    key_evt_t          evt_q, evt_d;
    logic              key_held_q, key_held_d;
    logic [BYTE_W-1:0] held_code_q, held_code_d;
    logic              held_ext_q, held_ext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              nextdata_n_q, nextdata_n_d;

    logic is_brk, is_ext, is_err, is_status;
    logic held_match;

    ps2_byte_classify u_classify (
        .data_i        (byte_q),
        .is_brk_c_o    (is_brk),
        .is_ext_c_o    (is_ext),
        .is_err_c_o    (is_err),
        .is_status_c_o (is_status)
    );

    assign held_match = key_held_q && (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

    // Next-state: FSM sequencing, byte classification, event/held/counter updates
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        key_held_d  = key_held_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        if (evt_valid_q && evt.evt_ready) begin
            evt_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ready && !evt_valid_q) begin
                    state_d = POP;
                    byte_d  = data;
                end
            end
            POP: begin
                state_d = GAP;
                if (is_brk) begin
                    brk_pend_d = 1'b1;
                end else if (is_ext) begin
                    ext_pend_d = 1'b1;
                end else if (is_err) begin
                    err_d      = 1'b1;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else if (!(is_status && !brk_pend_q && !ext_pend_q)) begin
                    evt_valid_d = 1'b1;
                    evt_d.code  = byte_q;
                    evt_d.ext   = ext_pend_q;
                    evt_d.brk   = brk_pend_q;
                    evt_d.rpt   = 1'b0;
                    brk_pend_d  = 1'b0;
                    ext_pend_d  = 1'b0;
                    if (!brk_pend_q) begin
                        if (held_match) begin
                            evt_d.rpt = 1'b1;
                        end else begin
                            key_held_d  = 1'b1;
                            held_code_d = byte_q;
                            held_ext_d  = ext_pend_q;
                        end
                    end else if (held_match) begin
                        key_held_d = 1'b0;
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Receiver overflow edge poisons any half-assembled prefix sequence
        if (overflow && !ovf_q) begin
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end

        nextdata_n_d = (state_d != POP);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
            ovf_q        <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_q        <= '0;
            key_held_q   <= 1'b0;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            nextdata_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
            ovf_q        <= overflow;
            evt_valid_q  <= evt_valid_d;
            evt_q        <= evt_d;
            key_held_q   <= key_held_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            nextdata_n_q <= nextdata_n_d;
        end
    end

    assign nextdata_n    = nextdata_n_q;
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_code  = evt_q.code;
    assign evt.evt_ext   = evt_q.ext;
    assign evt.evt_brk   = evt_q.brk;
    assign evt.evt_rpt   = evt_q.rpt;
    assign key_held      = key_held_q;
    assign held_code     = held_code_q;
    assign held_ext      = held_ext_q;
    assign press_cnt     = cnt_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: receiver FIFO model, event capture and hand-computed expectations.
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

    logic       clk;
    logic       clrn;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;
    logic       key_held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_cnt;
    logic       err;

    ps2_key_ctrl_if evt_if ();

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .evt        (evt_if),
        .key_held   (key_held),
        .held_code  (held_code),
        .held_ext   (held_ext),
        .press_cnt  (press_cnt),
        .err        (err)
    );

    int n_cmp;
    int n_bad;
    int pulses;
    int dbl_viol;
    int bp_viol;
    bit prev_low;

    logic [7:0]  fifo[$];
    logic [11:0] evq[$];
    logic [11:0] expq[$];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ev(input logic [7:0] c, input logic x, input logic b,
                                       input logic r, input logic h);
        return {c, x, b, r, h};
    endfunction

    // Receiver FIFO model: pops once per low nextdata_n cycle, head updated mid-cycle
    always @(negedge clk) begin
        if (clrn && !nextdata_n) begin
            pulses++;
            if (prev_low) dbl_viol++;
            if (evt_if.evt_valid) bp_viol++;
            if (fifo.size() != 0) fifo.delete(0);
        end
        prev_low = clrn && !nextdata_n;
        ready    = (fifo.size() != 0);
        data     = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    // Capture each transferred event along with the held flag seen at transfer
    always @(posedge clk) begin
        if (clrn && evt_if.evt_valid && evt_if.evt_ready)
            evq.push_back({evt_if.evt_code, evt_if.evt_ext, evt_if.evt_brk, evt_if.evt_rpt, key_held});
    end

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        fifo.push_back(a);
        fifo.push_back(b);
        fifo.push_back(c);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (fifo.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        if (n >= budget) chk({tag, "_timeout"}, n, 0);
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_nevt"}, evq.size(), expq.size());
        foreach (expq[i])
            chk($sformatf("%s_evt%0d", tag, i),
                (i < evq.size()) ? 32'(evq[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
        evq.delete();
        expq.delete();
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        fifo.delete();
        evq.delete();
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        clrn   = 1'b1;
        pulses = 0;
    endtask

    initial begin
        int n;
        clk = 1'b0; clrn = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0;
        evt_if.evt_ready = 1'b1;
        n_cmp = 0; n_bad = 0; pulses = 0; dbl_viol = 0; bp_viol = 0; prev_low = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_evt_valid", evt_if.evt_valid, 0);
        chk("rst_evt_code", evt_if.evt_code, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_held_code", held_code, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_err", err, 0);
        clrn   = 1'b1;
        pulses = 0;

        // Plain stroke
        push3(8'h1C, 8'hF0, 8'h1C);
        drain("plain", 200);
        expq.push_back(ev(8'h1C, 0, 0, 0, 1));
        expq.push_back(ev(8'h1C, 0, 1, 0, 0));
        check_events("plain");
        chk("plain_cnt", press_cnt, 1);
        chk("plain_held", key_held, 0);
        chk("plain_pulses", pulses, 3);

        // Extended key
        pulses = 0;
        fifo.push_back(8'hE0);
        fifo.push_back(8'h75);
        push3(8'hE0, 8'hF0, 8'h75);
        drain("ext", 200);
        expq.push_back(ev(8'h75, 1, 0, 0, 1));
        expq.push_back(ev(8'h75, 1, 1, 0, 0));
        check_events("ext");
        chk("ext_cnt", press_cnt, 2);
        chk("ext_held_code", held_code, 8'h75);
        chk("ext_held_ext", held_ext, 1);
        chk("ext_pulses", pulses, 5);

        // Typematic under backpressure
        pulses = 0;
        evt_if.evt_ready = 1'b0;
        push3(8'h1C, 8'h1C, 8'h1C);
        fifo.push_back(8'hF0);
        fifo.push_back(8'h1C);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_stall_pulses", pulses, 1);
        chk("bp_stall_valid", evt_if.evt_valid, 1);
        chk("bp_stall_code", evt_if.evt_code, 8'h1C);
        evt_if.evt_ready = 1'b1;
        drain("bp", 400);
        expq.push_back(ev(8'h1C, 0, 0, 0, 1));
        expq.push_back(ev(8'h1C, 0, 0, 1, 1));
        expq.push_back(ev(8'h1C, 0, 0, 1, 1));
        expq.push_back(ev(8'h1C, 0, 1, 0, 0));
        check_events("bp");
        chk("bp_cnt", press_cnt, 3);
        chk("bp_pulses", pulses, 5);

        // Noise: status byte dropped, error byte kills a stray break prefix
        fifo.push_back(8'hAA);
        drain("noise_aa", 200);
        check_events("noise_aa");
        chk("noise_aa_err", err, 0);
        push3(8'hF0, 8'hFF, 8'h1C);
        drain("noise", 200);
        expq.push_back(ev(8'h1C, 0, 0, 0, 1));
        check_events("noise");
        chk("noise_err", err, 1);
        chk("noise_cnt", press_cnt, 3);

        // Overflow edge sets err and clears a pending break
        do_reset();
        chk("ovf_err_after_rst", err, 0);
        fifo.push_back(8'hF0);
        drain("ovf_pre", 200);
        overflow = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        overflow = 1'b0;
        fifo.push_back(8'h1C);
        drain("ovf", 200);
        expq.push_back(ev(8'h1C, 0, 0, 0, 1));
        check_events("ovf");
        chk("ovf_err", err, 1);

        // Reset in the middle of a pop leaves the byte in the FIFO
        do_reset();
        fifo.push_back(8'h1C);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (nextdata_n !== 1'b0 && n < 50);
        if (n >= 50) chk("midpop_timeout", n, 0);
        clrn = 1'b0;
        #1;
        chk("midpop_nextdata_n", nextdata_n, 1);
        chk("midpop_evt_valid", evt_if.evt_valid, 0);
        chk("midpop_err", err, 0);
        chk("midpop_fifo", fifo.size(), 1);
        repeat (2) @(posedge clk);
        #1;
        clrn   = 1'b1;
        pulses = 0;
        drain("midpop", 200);
        expq.push_back(ev(8'h1C, 0, 0, 0, 1));
        check_events("midpop");
        chk("midpop_pulses", pulses, 1);

        // Counter wrap across 256 strokes
        do_reset();
        for (int i = 0; i < 255; i++) push3(8'h1C, 8'hF0, 8'h1C);
        drain("wrap255", 10000);
        chk("wrap_cnt255", press_cnt, 255);
        push3(8'h1C, 8'hF0, 8'h1C);
        drain("wrap256", 200);
        chk("wrap_cnt0", press_cnt, 0);
        chk("wrap_nevt", evq.size(), 512);
        evq.delete();

        chk("strobe_double_low", dbl_viol, 0);
        chk("strobe_while_valid", bp_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
